// File: rtl/ex_pkg.sv
// Shared types and encodings for the EX stage: ALU decode, forward select,
// FSM states and the registered control bundle.
package ex_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_MULT = 6'h18;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MULT, OP_NONE
    } alu_op_e;

    typedef enum logic [1:0] {FWD_RF, FWD_EXMEM, FWD_MEMWB} fwd_sel_e;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

    typedef struct packed {
        logic [1:0] wb;
        logic       branch;
        logic       memread;
        logic       memwrite;
    } ctl_t;

    function automatic alu_op_e decode_alu(input logic [1:0] aluop, input logic [5:0] funct);
        alu_op_e op;
        op = OP_NONE;
        case (aluop)
            ALUOP_ADD:   op = OP_ADD;
            ALUOP_SUB:   op = OP_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FN_ADD:  op = OP_ADD;
                    FN_SUB:  op = OP_SUB;
                    FN_AND:  op = OP_AND;
                    FN_OR:   op = OP_OR;
                    FN_SLT:  op = OP_SLT;
                    FN_MULT: op = OP_MULT;
                    default: op = OP_NONE;
                endcase
            end
            default:     op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mul_iter.sv
// Radix-2 shift-add multiplier, one partial product per cycle, DATA_W steps.
// Keeps only the low DATA_W bits of the unsigned product.
module mul_iter #(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned CNT_W = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);

    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]  count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else if (abort_i) begin
            count_q <= '0;
        end else if (start_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            count_q  <= CNT_W'(DATA_W);
        end else if (count_q != '0) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q - 1'b1;
        end
    end

    // High during the cycle whose edge performs the final step.
    assign done_o    = (count_q == CNT_W'(1));
    assign product_o = acc_q;

endmodule

// File: rtl/ex_stage_pipe.sv
// MIPS execute stage with EX/MEM register: operand bypass, single-cycle ALU,
// iterative multiply with back-pressure, and stall/flush handling.
module ex_stage_pipe
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              mem_stall,
    input  logic [1:0]        wb_ctl,
    input  logic [2:0]        m_ctl,
    input  logic              regdst,
    input  logic              alusrc,
    input  logic [1:0]        aluop,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] npcout,
    input  logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] rdata2,
    input  logic [DATA_W-1:0] s_extendout,
    input  logic [REG_AW-1:0] instr_rs,
    input  logic [REG_AW-1:0] instrout_2016,
    input  logic [REG_AW-1:0] instrout_1511,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic              out_valid,
    output logic [1:0]        wb_ctlout,
    output logic              branch,
    output logic              memread,
    output logic              memwrite,
    output logic              zero,
    output logic [DATA_W-1:0] EX_MEM_NPC,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] rdata2out,
    output logic [REG_AW-1:0] five_bit_muxout,
    output logic              ex_busy
);

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    ctl_t              ctl_q, ctl_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] npc_q, npc_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic [REG_AW-1:0] dst_q, dst_d;

    ctl_t              pend_ctl_q;
    logic [DATA_W-1:0] pend_npc_q;
    logic [DATA_W-1:0] pend_rd2_q;
    logic [REG_AW-1:0] pend_dst_q;

    fwd_sel_e          fwd_a, fwd_b;
    logic              exm_ok, mwb_ok;
    logic [DATA_W-1:0] opa, opb_fwd, opb, alu_res, tgt_in;
    logic [REG_AW-1:0] dst_in;
    ctl_t              ctl_in;
    alu_op_e           op;
    logic              is_mult, accept, mul_start, mul_abort, mul_done;
    logic [DATA_W-1:0] mul_product;

    always_comb begin
        exm_ok = valid_q && ctl_q.wb[1] && (dst_q != '0);
        mwb_ok = memwb_regwrite && (memwb_rd != '0);
        fwd_a  = FWD_RF;
        fwd_b  = FWD_RF;
        if (exm_ok && dst_q == instr_rs)            fwd_a = FWD_EXMEM;
        else if (mwb_ok && memwb_rd == instr_rs)    fwd_a = FWD_MEMWB;
        if (exm_ok && dst_q == instrout_2016)       fwd_b = FWD_EXMEM;
        else if (mwb_ok && memwb_rd == instrout_2016) fwd_b = FWD_MEMWB;
    end

    always_comb begin
        case (fwd_a)
            FWD_EXMEM: opa = alu_q;
            FWD_MEMWB: opa = memwb_data;
            default:   opa = rdata1;
        endcase
        case (fwd_b)
            FWD_EXMEM: opb_fwd = alu_q;
            FWD_MEMWB: opb_fwd = memwb_data;
            default:   opb_fwd = rdata2;
        endcase
    end

    assign opb     = alusrc ? s_extendout : opb_fwd;
    assign op      = decode_alu(aluop, funct);
    assign is_mult = (op == OP_MULT);
    assign ctl_in  = ctl_t'({wb_ctl, m_ctl});
    assign dst_in  = regdst ? instrout_1511 : instrout_2016;
    assign tgt_in  = npcout + (s_extendout << 2);

    always_comb begin
        case (op)
            OP_ADD:  alu_res = opa + opb;
            OP_SUB:  alu_res = opa - opb;
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(opa) < $signed(opb))};
            default: alu_res = '0;
        endcase
    end

    assign in_ready  = (state_q == IDLE) && !mem_stall && !flush;
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && is_mult;
    assign mul_abort = flush && (state_q != IDLE);
    assign ex_busy   = (state_q != IDLE);

    mul_iter #(.DATA_W(DATA_W)) u_mul (
        .clk      (clk),
        .rst_n    (reset),
        .start_i  (mul_start),
        .abort_i  (mul_abort),
        .a_i      (opa),
        .b_i      (opb),
        .done_o   (mul_done),
        .product_o(mul_product)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (mul_start) state_d = MUL;
            MUL:  if (flush) state_d = IDLE;
                  else if (mul_done) state_d = DONE;
            DONE: if (flush || !mem_stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Flush has priority over a finished product, so a killed multiply yields a bubble.
    always_comb begin
        valid_d = valid_q;
        ctl_d   = ctl_q;
        zero_d  = zero_q;
        npc_d   = npc_q;
        alu_d   = alu_q;
        rd2_d   = rd2_q;
        dst_d   = dst_q;
        if (!mem_stall) begin
            if (accept && !is_mult) begin
                valid_d = 1'b1;
                ctl_d   = ctl_in;
                zero_d  = (alu_res == '0);
                npc_d   = tgt_in;
                alu_d   = alu_res;
                rd2_d   = opb_fwd;
                dst_d   = dst_in;
            end else if (state_q == DONE && !flush) begin
                valid_d = 1'b1;
                ctl_d   = pend_ctl_q;
                zero_d  = (mul_product == '0);
                npc_d   = pend_npc_q;
                alu_d   = mul_product;
                rd2_d   = pend_rd2_q;
                dst_d   = pend_dst_q;
            end else begin
                valid_d = 1'b0;
                ctl_d   = '0;
                zero_d  = 1'b0;
                npc_d   = '0;
                alu_d   = '0;
                rd2_d   = '0;
                dst_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ctl_q   <= '0;
            zero_q  <= 1'b0;
            npc_q   <= '0;
            alu_q   <= '0;
            rd2_q   <= '0;
            dst_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctl_q   <= ctl_d;
            zero_q  <= zero_d;
            npc_q   <= npc_d;
            alu_q   <= alu_d;
            rd2_q   <= rd2_d;
            dst_q   <= dst_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_ctl_q <= '0;
            pend_npc_q <= '0;
            pend_rd2_q <= '0;
            pend_dst_q <= '0;
        end else if (mul_start) begin
            pend_ctl_q <= ctl_in;
            pend_npc_q <= tgt_in;
            pend_rd2_q <= opb_fwd;
            pend_dst_q <= dst_in;
        end
    end

    assign out_valid       = valid_q;
    assign wb_ctlout       = ctl_q.wb;
    assign branch          = ctl_q.branch;
    assign memread         = ctl_q.memread;
    assign memwrite        = ctl_q.memwrite;
    assign zero            = zero_q;
    assign EX_MEM_NPC      = npc_q;
    assign alu_result      = alu_q;
    assign rdata2out       = rd2_q;
    assign five_bit_muxout = dst_q;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Bench for ex_stage_pipe: directed scenarios plus random single-cycle traffic,
// checked against a behavioural model of the EX/MEM contents.
module tb_ex_stage_pipe;

    logic        clk, reset;
    logic        in_valid, in_ready, flush, mem_stall;
    logic [1:0]  wb_ctl, aluop;
    logic [2:0]  m_ctl;
    logic        regdst, alusrc;
    logic [5:0]  funct;
    logic [31:0] npcout, rdata1, rdata2, s_extendout, memwb_data;
    logic [4:0]  instr_rs, instrout_2016, instrout_1511, memwb_rd;
    logic        memwb_regwrite;
    logic        out_valid, branch, memread, memwrite, zero, ex_busy;
    logic [1:0]  wb_ctlout;
    logic [31:0] EX_MEM_NPC, alu_result, rdata2out;
    logic [4:0]  five_bit_muxout;

    ex_stage_pipe #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .mem_stall(mem_stall), .wb_ctl(wb_ctl), .m_ctl(m_ctl),
        .regdst(regdst), .alusrc(alusrc), .aluop(aluop), .funct(funct),
        .npcout(npcout), .rdata1(rdata1), .rdata2(rdata2), .s_extendout(s_extendout),
        .instr_rs(instr_rs), .instrout_2016(instrout_2016), .instrout_1511(instrout_1511),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .out_valid(out_valid), .wb_ctlout(wb_ctlout), .branch(branch), .memread(memread),
        .memwrite(memwrite), .zero(zero), .EX_MEM_NPC(EX_MEM_NPC), .alu_result(alu_result),
        .rdata2out(rdata2out), .five_bit_muxout(five_bit_muxout), .ex_busy(ex_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [1:0]  wb;
        logic        br, mr, mw, z;
        logic [31:0] npc, alu, rd2;
        logic [4:0]  dst;
    } ent_t;

    ent_t ex, pend;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   lat;
    logic [5:0] fn_tab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(ex.v));
        chk({tag, ".wb"},    32'(wb_ctlout), 32'(ex.wb));
        chk({tag, ".m"},     32'({branch, memread, memwrite}), 32'({ex.br, ex.mr, ex.mw}));
        chk({tag, ".zero"},  32'(zero), 32'(ex.z));
        chk({tag, ".npc"},   EX_MEM_NPC, ex.npc);
        chk({tag, ".alu"},   alu_result, ex.alu);
        chk({tag, ".rd2"},   rdata2out, ex.rd2);
        chk({tag, ".dst"},   32'(five_bit_muxout), 32'(ex.dst));
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf);
        if (ex.v && ex.wb[1] && ex.dst != 0 && ex.dst == src) return ex.alu;
        if (memwb_regwrite && memwb_rd != 0 && memwb_rd == src) return memwb_data;
        return rf;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [1:0] aop, input logic [5:0] fn,
                                            input logic [31:0] a, input logic [31:0] b);
        if (aop == 2'b00) return a + b;
        if (aop == 2'b01) return a - b;
        if (aop == 2'b10) begin
            case (fn)
                6'h20: return a + b;
                6'h22: return a - b;
                6'h24: return a & b;
                6'h25: return a | b;
                6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h18: return a * b;
                default: return 32'd0;
            endcase
        end
        return 32'd0;
    endfunction

    function automatic ent_t predict_single();
        ent_t e;
        logic [31:0] a, bf, b;
        a  = fwd(instr_rs, rdata1);
        bf = fwd(instrout_2016, rdata2);
        b  = alusrc ? s_extendout : bf;
        e.v   = 1'b1;
        e.wb  = wb_ctl;
        {e.br, e.mr, e.mw} = m_ctl;
        e.alu = alu_ref(aluop, funct, a, b);
        e.z   = (e.alu == 32'd0);
        e.npc = npcout + (s_extendout << 2);
        e.rd2 = bf;
        e.dst = regdst ? instrout_1511 : instrout_2016;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_r(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] r1, input logic [31:0] r2);
        in_valid = 1'b1; aluop = 2'b10; funct = fn;
        instr_rs = rs; instrout_2016 = rt; instrout_1511 = rd;
        rdata1 = r1; rdata2 = r2; regdst = 1'b1; alusrc = 1'b0;
        wb_ctl = 2'b10; m_ctl = 3'b000; npcout = 32'h400; s_extendout = 32'h10;
    endtask

    // One cycle with the stage idle: predict EX/MEM, clock, compare.
    task automatic cycle_single(input string tag);
        ent_t n;
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(!mem_stall && !flush));
        chk({tag, ".busy"}, 32'(ex_busy), 32'd0);
        if (in_valid && !flush && !mem_stall) n = predict_single();
        else if (mem_stall)                    n = ex;
        else                                   n = '0;
        tick();
        ex = n;
        chk_all(tag);
    endtask

    task automatic run_mult(input string tag, input int stall_at, input int stall_len,
                            output int latency);
        int n;
        pend = predict_single();
        #1;
        chk({tag, ".accept_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        ex = '0;
        n = 0;
        while (!out_valid && n < 200) begin
            chk({tag, ".busy"}, 32'(ex_busy), 32'd1);
            chk({tag, ".ready_low"}, 32'(in_ready), 32'd0);
            chk_all({tag, ".wait"});
            mem_stall = (n >= stall_at && n < stall_at + stall_len);
            tick();
            n++;
        end
        mem_stall = 1'b0;
        latency = n;
        ex = pend;
        chk_all({tag, ".result"});
        chk({tag, ".busy_end"}, 32'(ex_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; mem_stall = 1'b0;
        wb_ctl = '0; m_ctl = '0; regdst = 1'b0; alusrc = 1'b0; aluop = '0; funct = '0;
        npcout = '0; rdata1 = '0; rdata2 = '0; s_extendout = '0;
        instr_rs = '0; instrout_2016 = '0; instrout_1511 = '0;
        memwb_regwrite = 1'b0; memwb_rd = '0; memwb_data = '0;
        ex = '0;

        #2 reset = 1'b0;
        #1 chk_all("reset_async");
        chk("reset_busy", 32'(ex_busy), 32'd0);
        tick(); tick();
        chk_all("reset_held");
        reset = 1'b1;

        // Back-to-back dependency through EX/MEM
        set_r(6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        cycle_single("add");
        chk("add_value", alu_result, 32'd12);
        set_r(6'h22, 5'd3, 5'd4, 5'd5, 32'd0, 32'd3);
        cycle_single("sub_fwd");
        chk("sub_fwd_value", alu_result, 32'd9);
        chk("sub_fwd_valid", 32'(out_valid), 32'd1);

        // EX/MEM beats MEM/WB; r0 is never forwarded
        set_r(6'h20, 5'd1, 5'd2, 5'd6, 32'd4, 32'd5);
        cycle_single("mk9");
        set_r(6'h20, 5'd6, 5'd0, 5'd8, 32'd100, 32'd0);
        memwb_regwrite = 1'b1; memwb_rd = 5'd6; memwb_data = 32'd4;
        cycle_single("prio");
        chk("prio_value", alu_result, 32'd9);
        set_r(6'h20, 5'd1, 5'd0, 5'd0, 32'hDEAD, 32'd0);
        memwb_regwrite = 1'b0;
        cycle_single("r0_dst");
        set_r(6'h20, 5'd0, 5'd0, 5'd9, 32'd0, 32'd1);
        memwb_regwrite = 1'b1; memwb_rd = 5'd0; memwb_data = 32'hBEEF;
        cycle_single("r0_nofwd");
        chk("r0_nofwd_value", alu_result, 32'd1);
        memwb_regwrite = 1'b0;
        set_r(6'h22, 5'd1, 5'd2, 5'd9, 32'd5, 32'd5);
        cycle_single("zero");
        chk("zero_flag", 32'(zero), 32'd1);

        // Randomised single-cycle traffic with stalls, flushes and bypasses
        for (int i = 0; i < 80; i++) begin
            in_valid = ($urandom_range(0, 9) < 8);
            mem_stall = ($urandom_range(0, 9) < 2);
            flush = ($urandom_range(0, 9) == 0);
            aluop = 2'($urandom_range(0, 3));
            funct = fn_tab[$urandom_range(0, 5)];
            regdst = 1'($urandom); alusrc = 1'($urandom);
            wb_ctl = 2'($urandom); m_ctl = 3'($urandom);
            instr_rs = 5'($urandom_range(0, 3));
            instrout_2016 = 5'($urandom_range(0, 3));
            instrout_1511 = 5'($urandom_range(0, 3));
            rdata1 = $urandom; rdata2 = $urandom; s_extendout = $urandom; npcout = $urandom;
            memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3));
            memwb_data = $urandom;
            cycle_single("rand");
        end
        flush = 1'b0; mem_stall = 1'b0; memwb_regwrite = 1'b0; in_valid = 1'b0;
        cycle_single("drain");

        // mult 7 x 6
        set_r(6'h18, 5'd1, 5'd2, 5'd7, 32'd7, 32'd6);
        run_mult("mul76", 1000, 0, lat);
        chk("mul76_latency", 32'(lat), 32'd33);
        chk("mul76_value", alu_result, 32'd42);

        // Forwarded operand into a multiply, stall during MUL has no effect
        set_r(6'h18, 5'd7, 5'd2, 5'd8, 32'd0, $urandom);
        run_mult("mul_fwd", 5, 3, lat);
        chk("mul_fwd_latency", 32'(lat), 32'd33);

        // Stall for three cycles while in DONE
        set_r(6'h18, 5'd1, 5'd2, 5'd9, $urandom, $urandom);
        run_mult("mul_stall", 32, 3, lat);
        chk("mul_stall_latency", 32'(lat), 32'd36);

        // Flush during MUL cycle 10
        in_valid = 1'b0;
        cycle_single("pre_flush");
        set_r(6'h18, 5'd1, 5'd2, 5'd10, 32'd3, 32'd3);
        #1;
        tick();
        in_valid = 1'b0;
        ex = '0;
        for (int n = 0; n < 10; n++) begin
            chk("flush_busy", 32'(ex_busy), 32'd1);
            if (n == 9) flush = 1'b1;
            tick();
        end
        flush = 1'b0;
        chk("flush_idle", 32'(ex_busy), 32'd0);
        chk_all("flush_bubble");
        for (int n = 0; n < 30; n++) cycle_single("flush_noresult");
        set_r(6'h20, 5'd1, 5'd2, 5'd11, 32'd20, 32'd22);
        cycle_single("post_flush_add");
        chk("post_flush_value", alu_result, 32'd42);

        // Flush never clears a loaded entry while MEM stalls; input is refused
        flush = 1'b1; mem_stall = 1'b1; in_valid = 1'b1;
        cycle_single("flush_hold");
        chk("flush_hold_valid", 32'(out_valid), 32'd1);
        mem_stall = 1'b0;
        cycle_single("flush_bubble2");
        flush = 1'b0;

        // Asynchronous reset with a valid entry held, then mid-multiply
        set_r(6'h20, 5'd1, 5'd2, 5'd12, 32'd1, 32'd2);
        cycle_single("pre_reset");
        in_valid = 1'b0; mem_stall = 1'b1;
        #2 reset = 1'b0;
        ex = '0;
        #1 chk_all("reset_entry");
        #1 reset = 1'b1; mem_stall = 1'b0;
        set_r(6'h18, 5'd1, 5'd2, 5'd13, 32'd9, 32'd9);
        tick();
        in_valid = 1'b0;
        for (int n = 0; n < 5; n++) tick();
        chk("pre_reset_busy", 32'(ex_busy), 32'd1);
        #2 reset = 1'b0;
        #1 chk("reset_mid_busy", 32'(ex_busy), 32'd0);
        chk("reset_mid_ready", 32'(in_ready), 32'd1);
        chk_all("reset_mid");
        #1 reset = 1'b1;
        set_r(6'h20, 5'd1, 5'd2, 5'd14, 32'd40, 32'd2);
        cycle_single("post_reset_add");
        chk("post_reset_value", alu_result, 32'd42);
        in_valid = 1'b0;
        for (int n = 0; n < 35; n++) cycle_single("post_reset_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage_pipe.md
# ex_stage_pipe

Parametrised execute stage with EX/MEM register, for the MIPS pipeline. Sits between the ID/EX register and the MEM stage. Over the single-cycle EX stage it adds three things: an internal forwarding unit (EX/MEM and MEM/WB bypass), a multi-cycle iterative multiplier, and valid/ready, stall and flush handshakes. Single-cycle ALU ops complete in one cycle. `mult` holds the stage busy and back-pressures ID.

## Interface
Parameters:
- DATA_W, 32, datapath width; also multiplier iteration count
- REG_AW, 5, register-address width

Ports (widths in terms of parameters):
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  ID/EX holds a valid instruction
- in_ready  out  1  stage accepts input this cycle
- flush  in  1  kill the instruction in EX (input or multiply in progress)
- mem_stall  in  1  MEM cannot accept; EX/MEM register holds
- wb_ctl  in  2  writeback control; bit1 = regwrite, bit0 = memtoreg
- m_ctl  in  3  {branch, memread, memwrite}
- regdst, alusrc  in  1 each  destination / operand-B select
- aluop  in  2  00 add, 01 sub, 10 R-type (decode funct)
- funct  in  6  R-type function field
- npcout, rdata1, rdata2, s_extendout  in  DATA_W  PC+4, register reads, sign-extended immediate
- instr_rs, instrout_2016, instrout_1511  in  REG_AW  rs, rt, rd fields
- memwb_regwrite  in  1  MEM/WB write enable (forward source)
- memwb_rd  in  REG_AW  MEM/WB destination register
- memwb_data  in  DATA_W  MEM/WB writeback data
- out_valid  out  1  EX/MEM holds a valid instruction
- wb_ctlout  out  2  registered writeback control
- branch, memread, memwrite, zero  out  1 each  registered control and ALU zero flag
- EX_MEM_NPC, alu_result, rdata2out  out  DATA_W  registered branch target, ALU result, forwarded store data
- five_bit_muxout  out  REG_AW  registered destination register
- ex_busy  out  1  multiplier active

## Operation
- Accept: `in_ready = (state==IDLE) && !mem_stall && !flush`. An instruction is accepted when `in_valid && in_ready`.
- Forwarding, operand A (rs) and operand B (rt), priority highest first:
  - EX/MEM register: `out_valid && wb_ctlout[1] && five_bit_muxout!=0 && five_bit_muxout==src` → use `alu_result`.
  - MEM/WB: `memwb_regwrite && memwb_rd!=0 && memwb_rd==src` → use `memwb_data`.
  - Otherwise use the register-file read.
- The forwarded B value feeds both the alusrc mux and `rdata2out`.
- Destination register: rd if `regdst`, else rt.
- Branch target: `npcout + (s_extendout << 2)`, truncated to DATA_W.
- ALU, selected by aluop:
  - aluop 00 → add; aluop 01 → sub.
  - aluop 10 with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 1 or 0), 0x18 mult.
  - Undefined funct → result 0.
  - zero = (result == 0).
- mult returns the low DATA_W bits of the unsigned product.
- FSM:
  - IDLE: an accepted mult latches the forwarded operands and all control, then → MUL with count = DATA_W. Other accepted ops load EX/MEM directly.
  - MUL: one shift-add step per cycle, count decrements; count reaching 0 → DONE.
  - DONE: if `!mem_stall`, load EX/MEM with the product and → IDLE; otherwise stay in DONE.
  - flush in MUL or DONE → IDLE, result discarded.
- `ex_busy = (state != IDLE)`.
- EX/MEM register update on each edge:
  - mem_stall=1: hold all outputs.
  - Otherwise, load the accepted single-cycle op, or the mult result from DONE.
  - Otherwise load a bubble: out_valid=0, wb_ctlout=0, branch/memread/memwrite=0; data fields don't-care, driven 0.
- flush never clears an already-loaded EX/MEM entry.
- Simultaneous flush and in_valid: input not accepted; bubble loaded if !mem_stall.

## Timing
- Reset (reset low, asynchronous): state=IDLE, count=0, every EX/MEM output 0. So out_valid=0, wb_ctlout=0, all control 0, data 0, five_bit_muxout=0.
- Reset asserted mid-multiply: result dropped, outputs zero immediately.
- Single-cycle op latency: 1 edge from acceptance to out_valid.
- mult latency: accepted at edge k, state DONE after edge k+DATA_W, result in EX/MEM at edge k+DATA_W+1 if no stall. Each stalled cycle in DONE adds one edge.
- in_ready is low for the whole MUL/DONE period.
- Forward path is combinational from EX/MEM outputs and memwb_* inputs to the ALU operands. No extra cycle is added.

## Structure
- Package `ex_pkg`:
  - aluop encodings and funct constants (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_MULT).
  - internal ALU-op enum.
  - forward-select enum (FWD_RF, FWD_EXMEM, FWD_MEMWB).
  - FSM state enum (IDLE, MUL, DONE).
- One sub-module, `mul_iter`: radix-2 shift-add multiplier with start, abort, count and done. It owns the MUL iteration and is parametrised by DATA_W.
- Forwarding, ALU, FSM and the EX/MEM register stay in the top level.

## Test plan
- add r3=r1+r2 (5+7), then sub using r3 back-to-back → EX/MEM forward; second result 12−r4, out_valid on consecutive cycles.
- Same source register hit by EX/MEM (value 9) and MEM/WB (value 4) → ALU uses 9. Destination r0 with data 0xDEAD → never forwarded.
- mult 7×6, DATA_W=32 → in_ready low for 33 cycles, alu_result=42 at edge k+33, ex_busy high for edges k+1..k+33.
- mem_stall held for 3 cycles while in DONE → output held, product appears 3 edges later. EX/MEM contents unchanged during the stall.
- flush during MUL cycle 10 → IDLE next edge, bubble (out_valid=0, wb_ctlout=0), next add accepted normally.
- reset pulled low mid-mult → all outputs 0 asynchronously; after release, first add completes with 1-cycle latency.
